// File: rtl/uart_cmd_decoder_if.sv
// UART command decoder bus bundle: receiver strobe, transmitter
// handshake and byte-write memory port.
interface uart_cmd_decoder_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_gnt;

  modport slave (
    input  rx_valid, rx_data, tx_ready, mem_gnt,
    output tx_valid, tx_data, mem_req, mem_addr, mem_wdata
  );

  modport master (
    output rx_valid, rx_data, tx_ready, mem_gnt,
    input  tx_valid, tx_data, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Byte-stream command decoder: set address, set length and
// streamed byte writes, answering each command with ACK or NAK.
module uart_cmd_decoder #(
  parameter logic [7:0] ACK_BYTE = 8'h06,
  parameter logic [7:0] NAK_BYTE = 8'h15
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_cmd_decoder_if.slave    bus,
  output logic [31:0]          addr_reg,
  output logic [31:0]          len_reg,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARG    = 3'd1;
  localparam logic [2:0] WDATA  = 3'd2;
  localparam logic [2:0] WISSUE = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [7:0] OP_ADDR  = 8'h30;
  localparam logic [7:0] OP_LEN   = 8'h31;
  localparam logic [7:0] OP_WRITE = 8'h32;

  logic [2:0] state;
  logic [1:0] cnt;
  logic       tgt_len;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      tgt_len       <= 1'b0;
      addr_reg      <= 32'd0;
      len_reg       <= 32'd0;
      overrun       <= 1'b0;
      bus.tx_valid  <= 1'b0;
      bus.tx_data   <= 8'd0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 8'd0;
    end else begin
      overrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            unique case (1'b1)
              (bus.rx_data == OP_ADDR),
              (bus.rx_data == OP_LEN): begin
                state   <= ARG;
                cnt     <= 2'd0;
                tgt_len <= bus.rx_data[0];
              end
              (bus.rx_data == OP_WRITE): begin
                if (len_reg != 32'd0) begin
                  state <= WDATA;
                end else begin
                  state        <= RESP;
                  bus.tx_valid <= 1'b1;
                  bus.tx_data  <= ACK_BYTE;
                end
              end
              default: begin
                state        <= RESP;
                bus.tx_valid <= 1'b1;
                bus.tx_data  <= NAK_BYTE;
              end
            endcase
          end
        end
        ARG: begin
          if (bus.rx_valid) begin
            if (tgt_len)
              len_reg <= {len_reg[23:0], bus.rx_data};
            else
              addr_reg <= {addr_reg[23:0], bus.rx_data};
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state        <= RESP;
              bus.tx_valid <= 1'b1;
              bus.tx_data  <= ACK_BYTE;
            end
          end
        end
        WDATA: begin
          if (bus.rx_valid) begin
            bus.mem_wdata <= bus.rx_data;
            bus.mem_addr  <= addr_reg;
            bus.mem_req   <= 1'b1;
            state         <= WISSUE;
          end
        end
        WISSUE: begin
          if (bus.rx_valid)
            overrun <= 1'b1;
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            addr_reg    <= addr_reg + 32'd1;
            len_reg     <= len_reg - 32'd1;
            // len_reg still holds the pre-decrement count here
            if (len_reg == 32'd1) begin
              state        <= RESP;
              bus.tx_valid <= 1'b1;
              bus.tx_data  <= ACK_BYTE;
            end else begin
              state <= WDATA;
            end
          end
        end
        RESP: begin
          if (bus.rx_valid)
            overrun <= 1'b1;
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: expected tx bytes and
// memory writes are queued at stimulus time and popped on handshakes.
module tb_uart_cmd_decoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_reg, len_reg;
  logic        busy, overrun;

  uart_cmd_decoder_if bus();

  uart_cmd_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .addr_reg (addr_reg),
    .len_reg  (len_reg),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ovr  = 0;

  logic [7:0]  exp_tx[$];
  logic [39:0] exp_mem[$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tx_valid && bus.mem_req)
        check("tx_mem_overlap", {bus.tx_valid, bus.mem_req}, 2'b00);
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0)
          check("tx_unexpected", {56'd0, bus.tx_data}, 64'hFFFF);
        else
          check("tx_data", {56'd0, bus.tx_data}, {56'd0, exp_tx.pop_front()});
      end
      if (bus.mem_req && bus.mem_gnt) begin
        if (exp_mem.size() == 0)
          check("mem_unexpected", {bus.mem_addr, bus.mem_wdata}, 64'hFFFF);
        else
          check("mem_write", {bus.mem_addr, bus.mem_wdata}, {24'd0, exp_mem.pop_front()});
      end
      if (overrun) n_ovr++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic set_reg(input logic [7:0] op, input logic [31:0] v);
    exp_tx.push_back(8'h06);
    send(op);
    for (int i = 3; i >= 0; i--) send(v[i*8 +: 8]);
    wait_idle(10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a0, l0;
    int ov0;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    bus.tx_ready = 1'b1;
    bus.mem_gnt  = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("rst_addr", {32'd0, addr_reg}, 64'd0);
    check("rst_len", {32'd0, len_reg}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_txv", {63'd0, bus.tx_valid}, 64'd0);
    check("rst_txd", {56'd0, bus.tx_data}, 64'd0);
    check("rst_memreq", {63'd0, bus.mem_req}, 64'd0);
    check("rst_memaddr", {32'd0, bus.mem_addr}, 64'd0);
    check("rst_ovr", {63'd0, overrun}, 64'd0);

    // set address with long gaps, partial values visible
    exp_tx.push_back(8'h06);
    send(8'h30);
    repeat (100) tick();
    send(8'hAB);
    check("addr_partial1", {32'd0, addr_reg}, 64'hAB);
    repeat (100) tick();
    send(8'hCD);
    check("addr_partial2", {32'd0, addr_reg}, 64'hABCD);
    repeat (100) tick();
    send(8'hEF);
    repeat (100) tick();
    send(8'hAB);
    wait_idle(10);
    check("addr_set", {32'd0, addr_reg}, 64'hABCDEFAB);
    check("len_after_addr", {32'd0, len_reg}, 64'd0);

    // set length then three-byte write
    set_reg(8'h30, 32'h100);
    set_reg(8'h31, 32'd3);
    check("len_set", {32'd0, len_reg}, 64'd3);
    exp_mem.push_back({32'h100, 8'h11});
    exp_mem.push_back({32'h101, 8'h22});
    exp_mem.push_back({32'h102, 8'h33});
    exp_tx.push_back(8'h06);
    send(8'h32);
    send(8'h11);
    tick();
    send(8'h22);
    tick();
    send(8'h33);
    wait_idle(10);
    check("wr_len", {32'd0, len_reg}, 64'd0);
    check("wr_addr", {32'd0, addr_reg}, 64'h103);

    // grant backpressure with an injected byte
    set_reg(8'h30, 32'h200);
    set_reg(8'h31, 32'd2);
    ov0 = n_ovr;
    bus.mem_gnt = 1'b0;
    exp_mem.push_back({32'h200, 8'hAA});
    exp_mem.push_back({32'h201, 8'hBB});
    exp_tx.push_back(8'h06);
    send(8'h32);
    send(8'hAA);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) send(8'hEE);
      else tick();
      if (i % 4 == 0) begin
        check("bp_req", {63'd0, bus.mem_req}, 64'd1);
        check("bp_addr", {32'd0, bus.mem_addr}, 64'h200);
        check("bp_wdata", {56'd0, bus.mem_wdata}, 64'hAA);
      end
    end
    check("bp_len_hold", {32'd0, len_reg}, 64'd2);
    bus.mem_gnt = 1'b1;
    tick();
    tick();
    send(8'hBB);
    wait_idle(10);
    check("bp_overrun", n_ovr - ov0, 64'd1);
    check("bp_addr_end", {32'd0, addr_reg}, 64'h202);

    // unknown opcode
    a0 = addr_reg;
    l0 = len_reg;
    exp_tx.push_back(8'h15);
    send(8'h7F);
    wait_idle(10);
    check("nak_addr", {32'd0, addr_reg}, {32'd0, a0});
    check("nak_len", {32'd0, l0}, {32'd0, len_reg});

    // write with zero length
    exp_tx.push_back(8'h06);
    send(8'h32);
    wait_idle(10);
    check("zero_len_addr", {32'd0, addr_reg}, 64'h202);

    // address wrap
    set_reg(8'h30, 32'hFFFF_FFFF);
    set_reg(8'h31, 32'd1);
    exp_mem.push_back({32'hFFFF_FFFF, 8'h5A});
    exp_tx.push_back(8'h06);
    send(8'h32);
    send(8'h5A);
    wait_idle(10);
    check("wrap_addr", {32'd0, addr_reg}, 64'd0);
    check("wrap_len", {32'd0, len_reg}, 64'd0);

    // reset mid-argument; no response expected for it
    set_reg(8'h30, 32'h1234);
    send(8'h30);
    send(8'hAA);
    send(8'hBB);
    do_reset();
    check("mid_rst_addr", {32'd0, addr_reg}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    set_reg(8'h31, 32'd1);
    check("post_rst_addr", {32'd0, addr_reg}, 64'd0);
    check("post_rst_len", {32'd0, len_reg}, 64'd1);

    // response stall
    bus.tx_ready = 1'b0;
    exp_tx.push_back(8'h15);
    send(8'h7F);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i % 10 == 0) begin
        check("stall_txv", {63'd0, bus.tx_valid}, 64'd1);
        check("stall_txd", {56'd0, bus.tx_data}, 64'h15);
        check("stall_busy", {63'd0, busy}, 64'd1);
      end
    end
    bus.tx_ready = 1'b1;
    tick();
    check("stall_release", {63'd0, busy}, 64'd0);
    check("stall_txv_low", {63'd0, bus.tx_valid}, 64'd0);

    tick();
    check("tx_queue_empty", exp_tx.size(), 64'd0);
    check("mem_queue_empty", exp_mem.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
